i2c_target_regs: RTL

//  I2C target (responder) with an 8-bit register-file port, the other end of the SoC's GPIO bit-banged I2C initiator.

---
 rtl/i2c_target_regs.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_regs.sv
// I2C target with an 8-bit register-file port: filters SCL/SDA, decodes the bus
// and turns addressed writes into wr_valid strobes and reads into serialised rd_data.
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_di,
  input  logic       sda_di,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_PTR, S_ACK_P, S_WR, S_ACK_W, S_RD, S_RACK, S_IGNORE
  } state_t;

  // Index 0 carries SCL, index 1 carries SDA through the whole input path.
  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         filt_q, filt_d, filt_prev_q;
  logic [1:0][CW-1:0] fcnt_q, fcnt_d;

  // The input path is left out of reset so a reset never fabricates bus edges.
  always_ff @(posedge clk) begin
    sync1_q     <= {sda_di, scl_di};
    sync2_q     <= sync1_q;
    filt_q      <= filt_d;
    filt_prev_q <= filt_q;
    fcnt_q      <= fcnt_d;
  end

  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == filt_q[i]) begin
        fcnt_d[i] = '0;
      end else if (fcnt_q[i] == CNT_MAX) begin
        filt_d[i] = sync2_q[i];
        fcnt_d[i] = '0;
      end else begin
        fcnt_d[i] = fcnt_q[i] + 1'b1;
      end
    end
  end

  logic scl_f, scl_p, sda_f, sda_p;
  logic scl_rise, scl_fall, start_ev, stop_ev;

  assign scl_f    = filt_q[0];
  assign scl_p    = filt_prev_q[0];
  assign sda_f    = filt_q[1];
  assign sda_p    = filt_prev_q[1];
  assign scl_rise = scl_f & ~scl_p;
  assign scl_fall = ~scl_f & scl_p;
  assign start_ev = scl_f & scl_p & sda_p & ~sda_f;
  assign stop_ev  = scl_f & scl_p & ~sda_p & sda_f;

  state_t     state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic [7:0] ptr_q, ptr_d;
  logic       wr_valid_q, wr_valid_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bitcnt_q   <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      ptr_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      ptr_q      <= ptr_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    rw_q    <= rw_d;
  end

  // sda_oe only ever moves on a filtered SCL fall, so it is stable while SCL is high.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    ptr_d      = ptr_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (wr_valid_q) ptr_d = ptr_q + 8'd1;

    if (start_ev) begin
      state_d  = S_ADDR;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
    end else if (stop_ev) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ADDR, S_PTR, S_WR: begin
          if (scl_rise) begin
            shift_d  = {shift_q[6:0], sda_f};
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall && bitcnt_q == 4'd8) begin
            bitcnt_d = '0;
            if (state_q == S_ADDR) begin
              if (shift_q[7:1] == TARGET_ADDR) begin
                state_d  = S_ACK_A;
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
                rw_d     = shift_q[0];
              end else begin
                state_d = S_IGNORE;
                busy_d  = 1'b0;
              end
            end else if (state_q == S_PTR) begin
              ptr_d    = shift_q;
              state_d  = S_ACK_P;
              sda_oe_d = 1'b1;
            end else begin
              wr_valid_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = shift_q;
              state_d    = S_ACK_W;
              sda_oe_d   = 1'b1;
            end
          end
        end
        S_ACK_A: begin
          if (scl_fall) begin
            bitcnt_d = '0;
            if (rw_q) begin
              state_d  = S_RD;
              shift_d  = rd_data;
              sda_oe_d = ~rd_data[7];
            end else begin
              state_d  = S_PTR;
              sda_oe_d = 1'b0;
            end
          end
        end
        S_ACK_P, S_ACK_W: begin
          if (scl_fall) begin
            state_d  = S_WR;
            bitcnt_d = '0;
            sda_oe_d = 1'b0;
          end
        end
        S_RD: begin
          if (scl_fall) begin
            if (bitcnt_q == 4'd7) begin
              state_d  = S_RACK;
              sda_oe_d = 1'b0;
            end else begin
              shift_d  = shift_q << 1;
              sda_oe_d = ~shift_q[6];
              bitcnt_d = bitcnt_q + 4'd1;
            end
          end
        end
        // A fall seen here always follows an ACK: a NACK has already left the state.
        S_RACK: begin
          if (scl_rise) begin
            if (sda_f) begin
              state_d = S_IGNORE;
              busy_d  = 1'b0;
            end else begin
              ptr_d = ptr_q + 8'd1;
            end
          end else if (scl_fall) begin
            state_d  = S_RD;
            bitcnt_d = '0;
            shift_d  = rd_data;
            sda_oe_d = ~rd_data[7];
          end
        end
        S_IGNORE: sda_oe_d = 1'b0;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_addr  = ptr_q;

endmodule
